// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with whole-block refill from instruction memory.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | lookup on ADDRESS; a hit answers in the same cycle
// S_MEM_READ | block request outstanding, waiting for MEM_BUSYWAIT low
module instruction_cache #(
    parameter int          NUM_BLOCKS = 8,
    parameter int          INDEX_BITS = 3,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    input  logic         FLUSH,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);

    localparam int TAG_BITS = 28 - INDEX_BITS;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MEM_READ = 1'b1;

    logic [0:0]            state;
    logic [27:0]           miss_addr;
    logic                  flush_pending;
    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_BITS-1:0]   tag_arr  [NUM_BLOCKS];
    logic [127:0]          data_arr [NUM_BLOCKS];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word_off;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [127:0]          line;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_addr;

    assign index       = ADDRESS[4 +: INDEX_BITS];
    assign tag         = ADDRESS[31 -: TAG_BITS];
    assign word_off    = ADDRESS[3:2];
    assign unused_addr = ^ADDRESS[1:0];
    assign fill_index  = miss_addr[INDEX_BITS-1:0];
    assign fill_tag    = miss_addr[27 -: TAG_BITS];

    assign line      = data_arr[index];
    assign hit       = (state == S_IDLE) && valid[index] && (tag_arr[index] == tag);
    assign fill_done = (state == S_MEM_READ) && !MEM_BUSYWAIT;

    // Gated by RESET so the fetch stage can reset its PC while the cache is held in reset.
    assign BUSYWAIT    = RESET && !hit;
    assign INSTRUCTION = hit ? line[{word_off, 5'b00000} +: 32] : NOP_INSTR;
    assign MEM_READ    = (state == S_MEM_READ);
    assign MEM_ADDRESS = miss_addr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= S_IDLE;
            miss_addr     <= '0;
            flush_pending <= 1'b0;
            valid         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (FLUSH) begin
                        valid <= '0;
                    end
                    if (!hit) begin
                        miss_addr <= ADDRESS[31:4];
                        state     <= S_MEM_READ;
                    end
                end
                default: begin
                    if (FLUSH) begin
                        flush_pending <= 1'b1;
                    end
                    if (!MEM_BUSYWAIT) begin
                        state         <= S_IDLE;
                        flush_pending <= 1'b0;
                        // A flush seen during the refill also kills the line just written.
                        if (flush_pending || FLUSH) begin
                            valid <= '0;
                        end else begin
                            valid[fill_index] <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data_arr[fill_index] <= MEM_READDATA;
            tag_arr[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else if (state == S_IDLE) begin
            if (hit) begin
                HIT_COUNT <= HIT_COUNT + 32'd1;
            end else begin
                MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: vector table with scoreboard queue plus a reset-mid-refill sequence.
module tb_instruction_cache;

    localparam int          LAT = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         CLK;
    logic         RESET;
    logic [31:0]  ADDRESS;
    logic         FLUSH;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int checks = 0;
    int errors = 0;
    int mem_cnt = 0;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .FLUSH        (FLUSH),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
`ifdef ICACHE_STATS_EN
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT),
`endif
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [27:0] blk, input logic [1:0] w);
        return {blk, 2'b00, w};
    endfunction

    assign MEM_READDATA = {word_of(MEM_ADDRESS, 2'd3), word_of(MEM_ADDRESS, 2'd2),
                           word_of(MEM_ADDRESS, 2'd1), word_of(MEM_ADDRESS, 2'd0)};

    // Memory model: data ready on the (LAT+1)-th cycle of MEM_READ; idle memory reports not busy.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            mem_cnt = mem_cnt + 1;
            MEM_BUSYWAIT = !(mem_cnt > LAT);
        end else begin
            mem_cnt = 0;
            MEM_BUSYWAIT = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        busy;
        logic [31:0] instr;
        logic        mr;
        logic [27:0] maddr;
        bit          chk_stats;
        logic [31:0] hits;
        logic [31:0] misses;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [31:0] addr, input logic flush, input logic busy,
                                input logic [31:0] instr, input logic mr, input logic [27:0] maddr);
        vec_t v;
        v.addr = addr; v.flush = flush; v.busy = busy; v.instr = instr;
        v.mr = mr; v.maddr = maddr; v.chk_stats = 1'b0; v.hits = '0; v.misses = '0;
        return v;
    endfunction

    task automatic add_hit(input logic [31:0] addr, input logic flush);
        vecs.push_back(mk(addr, flush, 1'b0, word_of(addr[31:4], addr[3:2]), 1'b0, '0));
    endtask

    // Detect cycle followed by LAT+1 MEM_READ cycles; flush_at selects which of those 5 cycles pulses FLUSH.
    task automatic add_miss(input logic [31:0] addr, input int flush_at);
        for (int i = 0; i < LAT + 2; i++) begin
            vecs.push_back(mk(addr, (i == flush_at), 1'b1, NOP, (i != 0), addr[31:4]));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        vec_t e;
        bit done;

        RESET = 1'b0; ADDRESS = '0; FLUSH = 1'b0; MEM_BUSYWAIT = 1'b0;

        add_miss(32'h0, -1);
        add_hit(32'h0, 1'b0); add_hit(32'h4, 1'b0); add_hit(32'h8, 1'b0); add_hit(32'hC, 1'b0);
        k = vecs.size();
        add_miss(32'h80, -1);
        vecs[k].chk_stats = 1'b1; vecs[k].hits = 32'd4; vecs[k].misses = 32'd1;
        add_hit(32'h80, 1'b0);
        add_miss(32'h0, -1);
        add_hit(32'h7, 1'b0);
        add_hit(32'h0, 1'b1);
        add_miss(32'h0, -1);
        add_hit(32'h0, 1'b0);
        add_miss(32'h10, 1);
        add_miss(32'h10, -1);
        add_hit(32'h10, 1'b0);
        add_miss(32'h0, -1);
        add_hit(32'h0, 1'b0);

        #3;
        check("reset busywait", BUSYWAIT, 1'b0);
        check("reset mem_read", MEM_READ, 1'b0);
        check("reset mem_address", MEM_ADDRESS, 28'h0);
        check("reset instruction", INSTRUCTION, NOP);
`ifdef ICACHE_STATS_EN
        check("reset hit_count", HIT_COUNT, 32'd0);
        check("reset miss_count", MISS_COUNT, 32'd0);
`endif

        @(posedge CLK); #1;
        RESET = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            ADDRESS = vecs[i].addr;
            FLUSH   = vecs[i].flush;
            exp_q.push_back(vecs[i]);
            @(negedge CLK);
            e = exp_q.pop_front();
            check($sformatf("v%0d busywait", i), BUSYWAIT, e.busy);
            check($sformatf("v%0d instruction", i), INSTRUCTION, e.instr);
            check($sformatf("v%0d mem_read", i), MEM_READ, e.mr);
            if (e.mr) check($sformatf("v%0d mem_address", i), MEM_ADDRESS, e.maddr);
`ifdef ICACHE_STATS_EN
            if (e.chk_stats) begin
                check($sformatf("v%0d hit_count", i), HIT_COUNT, e.hits);
                check($sformatf("v%0d miss_count", i), MISS_COUNT, e.misses);
            end
`endif
            @(posedge CLK); #1;
        end
        FLUSH = 1'b0;

        // Reset two cycles into a refill of block 0x20.
        ADDRESS = 32'h20;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("refill mem_read", MEM_READ, 1'b1);
        check("refill mem_address", MEM_ADDRESS, 28'h2);
        #2;
        RESET = 1'b0;
        #1;
        check("async reset mem_read", MEM_READ, 1'b0);
        check("async reset busywait", BUSYWAIT, 1'b0);
        check("async reset mem_address", MEM_ADDRESS, 28'h0);
        check("async reset instruction", INSTRUCTION, NOP);
`ifdef ICACHE_STATS_EN
        check("async reset hit_count", HIT_COUNT, 32'd0);
        check("async reset miss_count", MISS_COUNT, 32'd0);
`endif
        @(negedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("post reset miss busywait", BUSYWAIT, 1'b1);
        check("post reset miss instruction", INSTRUCTION, NOP);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) done = 1'b1;
        end
        check("refill after reset completes", done, 1'b1);
        check("refill after reset instruction", INSTRUCTION, word_of(28'h2, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
